// File: rtl/alien_depth_sorter_pkg.sv
// Shared types for the alien depth sorter: object record, sort key, FSM states.
package alien_depth_sorter_pkg;

    localparam int OBJ_LIMIT = 8;

    // One on-screen alien as produced by the game logic.
    typedef struct packed {
        logic [3:0] _r;          // distance, 0 = nearest
        logic [1:0] _type;
        logic [1:0] _frame_num;
        logic [7:0] angle;
    } AlienData;

    // {dead, distance}: dead slots always rank behind any live one.
    typedef logic [4:0] sort_key_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SORT,
        S_PUBLISH
    } sorter_state_t;

    function automatic sort_key_t alien_sort_key(AlienData d, logic alive);
        return {~alive, d._r};
    endfunction

endpackage

// File: rtl/alien_depth_sorter_cmp_swap.sv
// Single compare-exchange cell: the smaller key leaves on lo, the other on hi.
// Equal keys never swap, which keeps the overall sort stable.
module alien_cmp_swap
    import alien_depth_sorter_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  sort_key_t          a_key,
    input  AlienData           a_data,
    input  logic [IDX_W-1:0]   a_index,
    input  sort_key_t          b_key,
    input  AlienData           b_data,
    input  logic [IDX_W-1:0]   b_index,
    output AlienData           lo_data,
    output logic               lo_alive,
    output logic [IDX_W-1:0]   lo_index,
    output AlienData           hi_data,
    output logic               hi_alive,
    output logic [IDX_W-1:0]   hi_index
);

    logic swap;

    assign swap     = (a_key > b_key);

    assign lo_data  = swap ? b_data  : a_data;
    assign lo_alive = swap ? ~b_key[4] : ~a_key[4];
    assign lo_index = swap ? b_index : a_index;

    assign hi_data  = swap ? a_data  : b_data;
    assign hi_alive = swap ? ~a_key[4] : ~b_key[4];
    assign hi_index = swap ? a_index : b_index;

endmodule

// File: rtl/alien_depth_sorter.sv
// Per-frame depth sorter: snapshots the alien list on frame_tick, runs N passes of
// odd-even transposition sort and publishes the nearest-first list for the next frame.
module alien_depth_sorter
    import alien_depth_sorter_pkg::*;
#(
    parameter int N     = OBJ_LIMIT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  AlienData          obj_data     [0:N-1],
    input  logic [N-1:0]      obj_alive,
    output AlienData          sorted_data  [0:N-1],
    output logic [N-1:0]      sorted_alive,
    output logic [IDX_W-1:0]  sorted_index [0:N-1],
    output logic              sorted_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int HALF   = N / 2;
    localparam int PASS_W = $clog2(N + 1);

    typedef struct packed {
        AlienData         data;
        logic             alive;
        logic [IDX_W-1:0] index;
    } entry_t;

    sorter_state_t     state_reg;
    logic [PASS_W-1:0] pass_reg;
    entry_t            work_reg  [0:N-1];
    entry_t            net_next  [0:N-1];
    entry_t            cell_a    [0:HALF-1];
    entry_t            cell_b    [0:HALF-1];
    entry_t            cell_lo   [0:HALF-1];
    entry_t            cell_hi   [0:HALF-1];
    logic              odd_pass;

    AlienData          sorted_data_reg  [0:N-1];
    logic [N-1:0]      sorted_alive_reg;
    logic [IDX_W-1:0]  sorted_index_reg [0:N-1];
    logic              sorted_valid_reg;
    logic              busy_reg;

    assign odd_pass = pass_reg[0];

    genvar gi;

    // Compare-exchange cells; odd passes shift every pair up by one slot.
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_cell
            sort_key_t        a_key, b_key;
            AlienData         lo_data, hi_data;
            logic             lo_alive, hi_alive;
            logic [IDX_W-1:0] lo_index, hi_index;

            if (2 * gi + 2 < N) begin : g_pair
                assign cell_a[gi] = odd_pass ? work_reg[2*gi+1] : work_reg[2*gi];
                assign cell_b[gi] = odd_pass ? work_reg[2*gi+2] : work_reg[2*gi+1];
            end else begin : g_last
                assign cell_a[gi] = work_reg[2*gi];
                assign cell_b[gi] = work_reg[2*gi+1];
            end

            assign a_key = alien_sort_key(cell_a[gi].data, cell_a[gi].alive);
            assign b_key = alien_sort_key(cell_b[gi].data, cell_b[gi].alive);

            alien_cmp_swap #(.IDX_W(IDX_W)) u_cmp (
                .a_key    (a_key),
                .a_data   (cell_a[gi].data),
                .a_index  (cell_a[gi].index),
                .b_key    (b_key),
                .b_data   (cell_b[gi].data),
                .b_index  (cell_b[gi].index),
                .lo_data  (lo_data),
                .lo_alive (lo_alive),
                .lo_index (lo_index),
                .hi_data  (hi_data),
                .hi_alive (hi_alive),
                .hi_index (hi_index)
            );

            assign cell_lo[gi] = '{data: lo_data, alive: lo_alive, index: lo_index};
            assign cell_hi[gi] = '{data: hi_data, alive: hi_alive, index: hi_index};
        end
    endgenerate

    // Route cell results back to slot positions; unpaired end slots pass through.
    generate
        for (gi = 0; gi < N; gi++) begin : g_pos
            entry_t even_e, odd_e;

            if (gi % 2 == 0) begin : g_even_slot
                if (gi + 1 < N) begin : g_lo
                    assign even_e = cell_lo[gi/2];
                end else begin : g_keep
                    assign even_e = work_reg[gi];
                end
                if (gi >= 2) begin : g_hi
                    assign odd_e = cell_hi[(gi-2)/2];
                end else begin : g_keep0
                    assign odd_e = work_reg[gi];
                end
            end else begin : g_odd_slot
                assign even_e = cell_hi[gi/2];
                if (gi + 1 < N) begin : g_lo
                    assign odd_e = cell_lo[(gi-1)/2];
                end else begin : g_keep
                    assign odd_e = work_reg[gi];
                end
            end

            assign net_next[gi]     = odd_pass ? odd_e : even_e;
            assign sorted_data[gi]  = sorted_data_reg[gi];
            assign sorted_index[gi] = sorted_index_reg[gi];
        end
    endgenerate

    assign sorted_alive = sorted_alive_reg;
    assign sorted_valid = sorted_valid_reg;
    assign busy         = busy_reg;
    // A tick is only accepted from IDLE; any other cycle it is dropped and flagged.
    assign overrun      = frame_tick & busy_reg;

    // Sequencer: snapshot, N sort passes, publish on the final pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            pass_reg         <= '0;
            sorted_alive_reg <= '0;
            sorted_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            for (int i = 0; i < N; i++) begin
                work_reg[i]         <= '0;
                sorted_data_reg[i]  <= '0;
                sorted_index_reg[i] <= IDX_W'(i);
            end
        end else begin
            sorted_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (frame_tick) begin
                        state_reg <= S_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        work_reg[i].data  <= obj_data[i];
                        work_reg[i].alive <= obj_alive[i];
                        work_reg[i].index <= IDX_W'(i);
                    end
                    pass_reg  <= '0;
                    state_reg <= S_SORT;
                end
                S_SORT: begin
                    for (int i = 0; i < N; i++) begin
                        work_reg[i] <= net_next[i];
                    end
                    pass_reg <= pass_reg + 1'b1;
                    if (pass_reg == PASS_W'(N - 1)) begin
                        for (int i = 0; i < N; i++) begin
                            sorted_data_reg[i]  <= net_next[i].data;
                            sorted_alive_reg[i] <= net_next[i].alive;
                            sorted_index_reg[i] <= net_next[i].index;
                        end
                        sorted_valid_reg <= 1'b1;
                        state_reg        <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_depth_sorter.sv
// Bench for alien_depth_sorter: directed spec cases plus randomized frames
// checked against a counting-sort reference model.
module tb_alien_depth_sorter;
    import alien_depth_sorter_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    AlienData      obj_data     [0:N-1];
    logic [N-1:0]  obj_alive;
    AlienData      sorted_data  [0:N-1];
    logic [N-1:0]  sorted_alive;
    logic [2:0]    sorted_index [0:N-1];
    logic          sorted_valid;
    logic          busy;
    logic          overrun;

    int tests = 0;
    int fails = 0;

    AlienData      snap_data  [0:N-1];
    logic [N-1:0]  snap_alive;
    int            exp_index  [0:N-1];

    alien_depth_sorter #(.N(N), .IDX_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .obj_data     (obj_data),
        .obj_alive    (obj_alive),
        .sorted_data  (sorted_data),
        .sorted_alive (sorted_alive),
        .sorted_index (sorted_index),
        .sorted_valid (sorted_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic AlienData rand_alien(int rmax);
        AlienData d;
        d._r         = 4'($urandom_range(rmax, 0));
        d._type      = 2'($urandom);
        d._frame_num = 2'($urandom);
        d.angle      = 8'($urandom);
        return d;
    endfunction

    task automatic randomize_inputs(int rmax);
        for (int i = 0; i < N; i++) obj_data[i] = rand_alien(rmax);
        obj_alive = N'($urandom);
    endtask

    // Reference: bucket entries by rank = (dead ? 16 : 0) + distance, scanning
    // slots in ascending order inside each bucket, which is stable by construction.
    task automatic model_sort();
        int p = 0;
        for (int i = 0; i < N; i++) snap_data[i] = obj_data[i];
        snap_alive = obj_alive;
        for (int rank = 0; rank < 32; rank++)
            for (int i = 0; i < N; i++)
                if ((snap_alive[i] ? 0 : 16) + int'(snap_data[i]._r) == rank) begin
                    exp_index[p] = i;
                    p++;
                end
    endtask

    // Pulse frame_tick with the current inputs and watch a fixed window.
    task automatic run_frame(input bit scramble, output int lat, output int nvalid);
        model_sort();
        @(negedge clk);
        frame_tick = 1'b1;
        lat = -1;
        nvalid = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (scramble && k >= 2) randomize_inputs(15);
            #1;
            if (sorted_valid) begin
                nvalid++;
                if (lat < 0) lat = k;
            end
        end
        $display("[TB] frame alive=%b latency=%0d valids=%0d", snap_alive, lat, nvalid);
    endtask

    task automatic test_reset();
        randomize_inputs(15);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (sorted_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", sorted_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        tests++; if (sorted_alive !== '0) begin fails++; $display("FAIL reset_alive got %b exp 0", sorted_alive); end
        for (int i = 0; i < N; i++) begin
            tests++; if (sorted_data[i] !== '0) begin fails++; $display("FAIL reset_data[%0d] got %h exp 0", i, sorted_data[i]); end
            tests++; if (sorted_index[i] !== 3'(i)) begin fails++; $display("FAIL reset_index[%0d] got %0d exp %0d", i, sorted_index[i], i); end
        end
    endtask

    task automatic test_directed_sort();
        int r_in  [8] = '{7, 3, 15, 0, 9, 3, 1, 12};
        int r_exp [8] = '{0, 1, 3, 3, 7, 9, 12, 15};
        int i_exp [8] = '{3, 6, 1, 5, 0, 4, 7, 2};
        int lat, nv;
        randomize_inputs(15);
        for (int i = 0; i < N; i++) obj_data[i]._r = 4'(r_in[i]);
        obj_alive = 8'hFF;
        run_frame(1'b0, lat, nv);
        tests++; if (lat !== 10) begin fails++; $display("FAIL directed_latency got %0d exp 10", lat); end
        tests++; if (nv !== 1) begin fails++; $display("FAIL directed_valids got %0d exp 1", nv); end
        tests++; if (sorted_alive !== 8'hFF) begin fails++; $display("FAIL directed_alive got %b exp 11111111", sorted_alive); end
        for (int i = 0; i < N; i++) begin
            tests++; if (int'(sorted_data[i]._r) !== r_exp[i]) begin fails++; $display("FAIL directed_r[%0d] got %0d exp %0d", i, sorted_data[i]._r, r_exp[i]); end
            tests++; if (int'(sorted_index[i]) !== i_exp[i]) begin fails++; $display("FAIL directed_index[%0d] got %0d exp %0d", i, sorted_index[i], i_exp[i]); end
            tests++; if (sorted_data[i] !== snap_data[i_exp[i]]) begin fails++; $display("FAIL directed_data[%0d] got %h exp %h", i, sorted_data[i], snap_data[i_exp[i]]); end
        end
    endtask

    task automatic test_dead_tail();
        int i_exp [8] = '{2, 0, 1, 3, 4, 5, 6, 7};
        int lat, nv;
        randomize_inputs(15);
        for (int i = 0; i < N; i++) obj_data[i]._r = 4'd0;
        obj_data[0]._r = 4'd9;
        obj_data[2]._r = 4'd2;
        obj_alive = 8'b0000_0101;
        run_frame(1'b0, lat, nv);
        tests++; if (sorted_alive !== 8'b0000_0011) begin fails++; $display("FAIL dead_alive got %b exp 00000011", sorted_alive); end
        for (int i = 0; i < N; i++) begin
            tests++; if (int'(sorted_index[i]) !== i_exp[i]) begin fails++; $display("FAIL dead_index[%0d] got %0d exp %0d", i, sorted_index[i], i_exp[i]); end
        end
    endtask

    task automatic test_stability();
        int lat, nv;
        for (int pass = 0; pass < 2; pass++) begin
            randomize_inputs(15);
            for (int i = 0; i < N; i++) obj_data[i]._r = 4'd5;
            obj_alive = (pass == 0) ? 8'hFF : 8'h00;
            run_frame(1'b0, lat, nv);
            tests++; if (sorted_alive !== obj_alive) begin fails++; $display("FAIL stable_alive got %b exp %b", sorted_alive, obj_alive); end
            for (int i = 0; i < N; i++) begin
                tests++; if (sorted_index[i] !== 3'(i)) begin fails++; $display("FAIL stable_index[%0d] got %0d exp %0d", i, sorted_index[i], i); end
                tests++; if (sorted_data[i] !== obj_data[i]) begin fails++; $display("FAIL stable_data[%0d] got %h exp %h", i, sorted_data[i], obj_data[i]); end
            end
        end
    endtask

    task automatic test_overrun();
        int nv = 0, nov = 0, lat = -1, late_busy = 0;
        randomize_inputs(15);
        model_sort();
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            frame_tick = (k == 4 || k == 10);
            #1;
            if (frame_tick) begin
                tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_pulse_k%0d got %b exp 1", k, overrun); end
            end
            if (overrun) nov++;
            if (sorted_valid) begin nv++; if (lat < 0) lat = k; end
            if (k >= 11 && busy) late_busy++;
        end
        frame_tick = 1'b0;
        $display("[TB] overrun frame latency=%0d valids=%0d overruns=%0d", lat, nv, nov);
        tests++; if (nov !== 2) begin fails++; $display("FAIL overrun_count got %0d exp 2", nov); end
        tests++; if (nv !== 1) begin fails++; $display("FAIL overrun_valids got %0d exp 1", nv); end
        tests++; if (lat !== 10) begin fails++; $display("FAIL overrun_latency got %0d exp 10", lat); end
        tests++; if (late_busy !== 0) begin fails++; $display("FAIL overrun_idle got %0d busy cycles exp 0", late_busy); end
        for (int i = 0; i < N; i++) begin
            tests++; if (int'(sorted_index[i]) !== exp_index[i]) begin fails++; $display("FAIL overrun_index[%0d] got %0d exp %0d", i, sorted_index[i], exp_index[i]); end
        end
    endtask

    task automatic test_reset_mid_sort();
        int nv = 0, nb = 0, lat;
        randomize_inputs(15);
        obj_alive = 8'hFF;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            rst = (k == 5);
            #1;
            if (sorted_valid) nv++;
        end
        tests++; if (sorted_alive !== '0) begin fails++; $display("FAIL midrst_alive got %b exp 0", sorted_alive); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        for (int i = 0; i < N; i++) begin
            tests++; if (sorted_data[i] !== '0) begin fails++; $display("FAIL midrst_data[%0d] got %h exp 0", i, sorted_data[i]); end
            tests++; if (sorted_index[i] !== 3'(i)) begin fails++; $display("FAIL midrst_index[%0d] got %0d exp %0d", i, sorted_index[i], i); end
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            #1;
            if (sorted_valid) nv++;
            if (busy) nb++;
        end
        $display("[TB] reset mid-sort valids=%0d busy_cycles=%0d", nv, nb);
        tests++; if (nv !== 0) begin fails++; $display("FAIL midrst_no_valid got %0d exp 0", nv); end
        tests++; if (nb !== 0) begin fails++; $display("FAIL midrst_idle got %0d exp 0", nb); end
        randomize_inputs(6);
        run_frame(1'b0, lat, nv);
        tests++; if (lat !== 10) begin fails++; $display("FAIL midrst_resort_latency got %0d exp 10", lat); end
        for (int i = 0; i < N; i++) begin
            tests++; if (int'(sorted_index[i]) !== exp_index[i]) begin fails++; $display("FAIL midrst_resort_index[%0d] got %0d exp %0d", i, sorted_index[i], exp_index[i]); end
        end
    endtask

    task automatic test_snapshot();
        int lat, nv, changes = 0;
        AlienData      held_data  [0:N-1];
        logic [N-1:0]  held_alive;
        logic [2:0]    held_index [0:N-1];
        randomize_inputs(7);
        run_frame(1'b1, lat, nv);
        tests++; if (nv !== 1) begin fails++; $display("FAIL snap_valids got %0d exp 1", nv); end
        for (int i = 0; i < N; i++) begin
            tests++; if (int'(sorted_index[i]) !== exp_index[i]) begin fails++; $display("FAIL snap_index[%0d] got %0d exp %0d", i, sorted_index[i], exp_index[i]); end
            tests++; if (sorted_data[i] !== snap_data[exp_index[i]]) begin fails++; $display("FAIL snap_data[%0d] got %h exp %h", i, sorted_data[i], snap_data[exp_index[i]]); end
            tests++; if (sorted_alive[i] !== snap_alive[exp_index[i]]) begin fails++; $display("FAIL snap_alive[%0d] got %b exp %b", i, sorted_alive[i], snap_alive[exp_index[i]]); end
        end
        for (int i = 0; i < N; i++) begin held_data[i] = sorted_data[i]; held_index[i] = sorted_index[i]; end
        held_alive = sorted_alive;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            randomize_inputs(15);
            #1;
            if (sorted_alive !== held_alive) changes++;
            for (int i = 0; i < N; i++)
                if (sorted_data[i] !== held_data[i] || sorted_index[i] !== held_index[i]) changes++;
        end
        tests++; if (changes !== 0) begin fails++; $display("FAIL snap_hold got %0d changes exp 0", changes); end
    endtask

    task automatic test_random();
        int lat, nv;
        for (int f = 0; f < 20; f++) begin
            randomize_inputs((f % 2 == 0) ? 3 : 15);
            run_frame(1'b0, lat, nv);
            tests++; if (lat !== 10) begin fails++; $display("FAIL rand%0d_latency got %0d exp 10", f, lat); end
            for (int i = 0; i < N; i++) begin
                tests++; if (int'(sorted_index[i]) !== exp_index[i]) begin fails++; $display("FAIL rand%0d_index[%0d] got %0d exp %0d", f, i, sorted_index[i], exp_index[i]); end
                tests++; if (sorted_data[i] !== snap_data[exp_index[i]]) begin fails++; $display("FAIL rand%0d_data[%0d] got %h exp %h", f, i, sorted_data[i], snap_data[exp_index[i]]); end
                tests++; if (sorted_alive[i] !== snap_alive[exp_index[i]]) begin fails++; $display("FAIL rand%0d_alive[%0d] got %b exp %b", f, i, sorted_alive[i], snap_alive[exp_index[i]]); end
            end
        end
    endtask

    initial begin
        obj_alive = '0;
        for (int i = 0; i < N; i++) obj_data[i] = '0;
        test_reset();
        test_directed_sort();
        test_dead_tail();
        test_stability();
        test_overrun();
        test_reset_mid_sort();
        test_snapshot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
